// File: rtl/stop_watch_ctrl.sv
// stop_watch_ctrl: button-driven control FSM and display capture for a BCD stopwatch.
// Lap capture, lap counter and freeze are built only with STOP_WATCH_LAP_EN defined.
`default_nettype none

module stop_watch_ctrl #(
  parameter int LAP_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 btn_ss,
  input  logic                 btn_clr,
  input  logic                 btn_lap,
  input  logic [3:0]           d2,
  input  logic [3:0]           d1,
  input  logic [3:0]           d0,
  output logic                 go,
  output logic                 clr,
  output logic [3:0]           disp2,
  output logic [3:0]           disp1,
  output logic [3:0]           disp0,
  output logic                 frozen,
  output logic [LAP_CNT_W-1:0] lap_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

`ifdef STOP_WATCH_LAP_EN
  localparam logic C_LAP_EN = 1'b1;
`else
  localparam logic C_LAP_EN = 1'b0;
`endif

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [2:0]  r_prev;
  logic [2:0]  r_ev;
  logic        r_arm;
  logic        w_ev_ss;
  logic        w_ev_clr;
  logic        w_ev_lap;
  logic        w_go_nxt;
  logic        w_clr_nxt;
  logic [11:0] w_d;
  logic [11:0] w_disp_nxt;
  logic [11:0] r_disp;
  logic        r_go;
  logic        r_clr;

  assign w_d = {d2, d1, d0};

  // r_arm masks the first sample after reset so a held button cannot fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 3'b000;
      r_ev   <= 3'b000;
      r_arm  <= 1'b0;
    end else begin
      r_prev <= {btn_lap, btn_clr, btn_ss};
      r_ev   <= {btn_lap, btn_clr, btn_ss} & ~r_prev & {3{r_arm}};
      r_arm  <= 1'b1;
    end
  end

  assign w_ev_ss  = r_ev[0];
  assign w_ev_clr = r_ev[1];
  assign w_ev_lap = r_ev[2] & C_LAP_EN;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority ss > clr > lap: a higher event, even one ignored in this state, drops the rest.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ev_ss) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_ev_ss)        w_state_nxt = S_PAUSE;
        else if (w_ev_clr)  w_state_nxt = S_RUN;
        else if (w_ev_lap)  w_state_nxt = S_LAP;
      end
      S_LAP: begin
        if (w_ev_ss)        w_state_nxt = S_PAUSE;
        else if (w_ev_clr)  w_state_nxt = S_RUN;
        else if (w_ev_lap)  w_state_nxt = S_LAP;
      end
      S_PAUSE: begin
        if (w_ev_ss)        w_state_nxt = S_RUN;
        else if (w_ev_clr)  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_go_nxt  = (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
    w_clr_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_go   <= 1'b0;
      r_clr  <= 1'b1;
      r_disp <= 12'h000;
    end else begin
      r_go   <= w_go_nxt;
      r_clr  <= w_clr_nxt;
      r_disp <= w_disp_nxt;
    end
  end

`ifdef STOP_WATCH_LAP_EN
  logic                 w_capture;
  logic [11:0]          r_lap;
  logic [LAP_CNT_W-1:0] r_cnt;
  logic                 r_frozen;

  assign w_capture = w_ev_lap && !w_ev_ss && !w_ev_clr &&
                     ((r_state == S_RUN) || (r_state == S_LAP));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lap    <= 12'h000;
      r_cnt    <= '0;
      r_frozen <= 1'b0;
    end else begin
      if (w_capture) r_lap <= w_d;
      if (w_state_nxt == S_IDLE)
        r_cnt <= '0;
      else if (w_capture)
        r_cnt <= r_cnt + {{(LAP_CNT_W-1){1'b0}}, 1'b1};
      r_frozen <= (w_state_nxt == S_LAP);
    end
  end

  // A capture shows the new lap on the same edge it is taken.
  assign w_disp_nxt = (w_state_nxt == S_LAP) ? (w_capture ? w_d : r_lap) : w_d;
  assign frozen     = r_frozen;
  assign lap_cnt    = r_cnt;
`else
  assign w_disp_nxt = w_d;
  assign frozen     = 1'b0;
  assign lap_cnt    = '0;
`endif

  assign go    = r_go;
  assign clr   = r_clr;
  assign disp2 = r_disp[11:8];
  assign disp1 = r_disp[7:4];
  assign disp0 = r_disp[3:0];

endmodule

`default_nettype wire

// File: tb/tb_stop_watch_ctrl.sv
// tb_stop_watch_ctrl: directed and random stimulus against a behavioural stopwatch model.
`default_nettype none

module tb_stop_watch_ctrl;

`ifdef STOP_WATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mode_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_ss, btn_clr, btn_lap;
  logic [11:0] dv;
  logic        go, clr, frozen;
  logic [3:0]  disp2, disp1, disp0;
  logic [3:0]  lap_cnt;

  int n_vec = 0;
  int n_err = 0;

  mode_t       m_mode;
  int          m_cnt;
  logic [11:0] m_lap;
  logic [11:0] m_disp;
  logic [2:0]  m_h1, m_h2;
  int          m_edges;

  stop_watch_ctrl #(.LAP_CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
    .d2(dv[11:8]), .d1(dv[7:4]), .d0(dv[3:0]),
    .go(go), .clr(clr),
    .disp2(disp2), .disp1(disp1), .disp0(disp0),
    .frozen(frozen), .lap_cnt(lap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_lap = 12'h000; m_disp = 12'h000;
    m_h1 = 3'b000; m_h2 = 3'b000; m_edges = 0;
  endtask

  // One rising edge: a press is a 0->1 change between the two previous samples,
  // and only samples taken after reset release count.
  task automatic model_edge();
    logic [2:0] ev;
    int win;  // 0 none, 1 ss, 2 clr, 3 lap
    m_edges++;
    ev = (m_edges >= 3) ? (m_h1 & ~m_h2) : 3'b000;
    m_h2 = m_h1;
    m_h1 = {btn_lap, btn_clr, btn_ss};
    win = ev[0] ? 1 : ev[1] ? 2 : ev[2] ? 3 : 0;
    case (m_mode)
      M_IDLE:  if (win == 1) m_mode = M_RUN;
      M_RUN: begin
        if (win == 1) m_mode = M_PAUSE;
        else if (win == 3 && LAP_EN) begin
          m_lap = dv; m_cnt = (m_cnt + 1) % 16; m_mode = M_LAP;
        end
      end
      M_LAP: begin
        if (win == 1) m_mode = M_PAUSE;
        else if (win == 2) m_mode = M_RUN;
        else if (win == 3) begin m_lap = dv; m_cnt = (m_cnt + 1) % 16; end
      end
      M_PAUSE: begin
        if (win == 1) m_mode = M_RUN;
        else if (win == 2) begin m_mode = M_IDLE; m_cnt = 0; end
      end
      default: m_mode = M_IDLE;
    endcase
    m_disp = (m_mode == M_LAP) ? m_lap : dv;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".go"},      go,      (m_mode == M_RUN || m_mode == M_LAP));
    chk({tag, ".clr"},     clr,     (m_mode == M_IDLE));
    chk({tag, ".frozen"},  frozen,  (m_mode == M_LAP));
    chk({tag, ".lap_cnt"}, lap_cnt, m_cnt);
    chk({tag, ".disp"},    {disp2, disp1, disp0}, m_disp);
  endtask

  task automatic cycle(input logic [2:0] btn, input logic [11:0] d, input string tag);
    @(negedge clk);
    {btn_lap, btn_clr, btn_ss} = btn;
    dv = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic press(input logic [2:0] btn, input logic [11:0] d, input string tag);
    cycle(btn, d, tag);
    cycle(3'b000, d, tag);
  endtask

  initial begin
    reset_n = 1'b0;
    {btn_lap, btn_clr, btn_ss} = 3'b000;
    dv = 12'h000;
    model_reset();
    #12;
    chk("rst.go", go, 1'b0);
    chk("rst.clr", clr, 1'b1);
    chk("rst.disp", {disp2, disp1, disp0}, 12'h000);
    chk("rst.lap_cnt", lap_cnt, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(3'b000, 12'h000, "idle");
    cycle(3'b000, 12'h000, "idle");

    press(3'b001, 12'h005, "start");
    chk("start.go", go, 1'b1);
    chk("start.clr", clr, 1'b0);
    cycle(3'b000, 12'h100, "run");
    press(3'b001, 12'h123, "pause");
    chk("pause.go", go, 1'b0);
    chk("pause.disp", {disp2, disp1, disp0}, 12'h123);

    press(3'b001, 12'h040, "resume");
    press(3'b100, 12'h047, "lap1");
    chk("lap1.frozen", frozen, LAP_EN);
    chk("lap1.cnt", lap_cnt, LAP_EN ? 4'd1 : 4'd0);
    chk("lap1.go", go, 1'b1);
    cycle(3'b000, 12'h055, "lap_hold");
    cycle(3'b000, 12'h061, "lap_hold");
    chk("lap_hold.disp", {disp2, disp1, disp0}, LAP_EN ? 12'h047 : 12'h061);
    press(3'b100, 12'h092, "lap2");
    chk("lap2.disp", {disp2, disp1, disp0}, 12'h092);
    chk("lap2.cnt", lap_cnt, LAP_EN ? 4'd2 : 4'd0);

    press(3'b010, 12'h101, "unfreeze");
    chk("unfreeze.frozen", frozen, 1'b0);
    cycle(3'b000, 12'h102, "unfreeze_track");
    chk("unfreeze.disp", {disp2, disp1, disp0}, 12'h102);
    chk("unfreeze.cnt", lap_cnt, LAP_EN ? 4'd2 : 4'd0);

    press(3'b111, 12'h110, "all3");
    chk("all3.go", go, 1'b0);
    chk("all3.cnt", lap_cnt, LAP_EN ? 4'd2 : 4'd0);

    press(3'b010, 12'h111, "to_idle");
    chk("to_idle.clr", clr, 1'b1);
    chk("to_idle.cnt", lap_cnt, 4'd0);
    press(3'b001, 12'h200, "start2");
    press(3'b010, 12'h201, "clr_in_run");
    chk("clr_in_run.go", go, 1'b1);

    for (int i = 0; i < 17; i++) press(3'b100, 12'h300 + 12'(i), "lapwrap");
    chk("lapwrap.cnt", lap_cnt, LAP_EN ? 4'd1 : 4'd0);

    // Reset mid-run with start/stop held high across release.
    @(negedge clk);
    btn_ss = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.go", go, 1'b0);
    chk("midrst.clr", clr, 1'b1);
    chk("midrst.frozen", frozen, 1'b0);
    chk("midrst.disp", {disp2, disp1, disp0}, 12'h000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(3'b001, 12'h400, "held");
    chk("held.go", go, 1'b0);
    cycle(3'b000, 12'h400, "held_rel");

    begin
      logic [2:0]  lvl;
      logic [11:0] d;
      lvl = 3'b000;
      for (int i = 0; i < 600; i++) begin
        for (int b = 0; b < 3; b++)
          if ($urandom_range(0, 3) == 0) lvl[b] = ~lvl[b];
        d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        cycle(lvl, d, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
